multicycle_alu: RTL

Parametrised, registered ALU for the accumulator datapath. It replaces the purely combinational ALU with a clocked unit that has a start/ready/done handshake, a wider opcode set, status flags, and an optional iterative multiplier. It sits between the register file / accumulator and the write-back mux. The control FSM issues one operation per accept and writes back on `done`.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/shift_add_multiplier.sv | 63 ++++++
 rtl/multicycle_alu.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//
// Shared types for the multicycle ALU slice.
//
//   OPC_ENUM_WIDTH : width of the encoded opcode values. Any wider opCode bus
//                    on the ALU must carry zeros above these bits for the
//                    opcode to be legal.
//   alu_op_e       : opcode encoding. Values not listed here are illegal.
//   alu_state_e    : control FSM states. ST_MUL_RUN is only reachable when
//                    the MULTICYCLE_ALU_MUL_EN build macro is defined.
//   alu_flags_t    : registered status flags updated on each completion.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int OPC_ENUM_WIDTH = 4;

    typedef enum logic [OPC_ENUM_WIDTH-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_INC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_MUL = 4'd10
    } alu_op_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//
// Iterative unsigned multiplier: one shift-add step per clock, WIDTH steps
// per product. Operands are captured on `load`; the step counter then counts
// down from WIDTH to 0.
//
// `product` is the value the accumulator takes at the end of the current
// step. It is combinational, so that on the cycle where `last_step` is high
// the caller can register the complete product on the same edge that
// retires the final step.
//
// Ports:
//   clock        in  : rising-edge clock
//   resetN       in  : asynchronous active-low reset
//   load         in  : capture operands and restart the iteration
//   multiplicand in  : operand A (WIDTH)
//   multiplier   in  : operand B (WIDTH)
//   product      out : 2*WIDTH product as of the end of the current step
//   last_step    out : high during the final step of an iteration
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 load,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last_step
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_reg;   // multiplicand, shifted left each step
    logic [2*WIDTH-1:0] acc_reg;     // partial product
    logic [WIDTH-1:0]   mplier_reg;  // multiplier, LSB selects the add
    logic [CNT_W-1:0]   count_reg;   // steps remaining

    assign product   = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign last_step = (count_reg == CNT_W'(1));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else if (load) begin
            mcand_reg  <= {{WIDTH{1'b0}}, multiplicand};
            acc_reg    <= '0;
            mplier_reg <= multiplier;
            count_reg  <= CNT_W'(WIDTH);
        end else if (count_reg != '0) begin
            acc_reg    <= product;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//
// Registered ALU for the accumulator datapath with a start/ready/done
// handshake. Every op except MUL completes on the edge that accepts it;
// MUL runs an iterative shift-add multiplier for REGISTER_WIDTH cycles.
//
// Build option:
//   MULTICYCLE_ALU_MUL_EN  defined   -> MUL (opcode 10) supported, the
//                                       shift_add_multiplier is instantiated
//                                       and the MUL_RUN state is used.
//                          undefined -> opcode 10 is treated as illegal and
//                                       ready is 1 whenever out of reset.
//
// Ports:
//   clock        in  : rising-edge clock
//   resetN       in  : asynchronous active-low reset
//   start        in  : request, accepted on an edge with start && ready
//   opCode       in  : operation, sampled at accept (OPCODE_WIDTH)
//   accumulator  in  : operand A, sampled at accept (REGISTER_WIDTH)
//   register1    in  : operand B, sampled at accept (REGISTER_WIDTH)
//   ready        out : unit can accept a request
//   done         out : one-cycle completion pulse (continuous when
//                      accepts happen back to back)
//   aluResult    out : registered result, held until the next legal completion
//   flagZero     out : aluResult == 0
//   flagCarry    out : carry / borrow / shifted-out bit / MUL overflow
//   flagNegative out : aluResult MSB
//   illegal      out : last completion carried an illegal opcode
// -----------------------------------------------------------------------------
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int REGISTER_WIDTH = 8,
    parameter int OPCODE_WIDTH   = 4
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       start,
    input  logic [OPCODE_WIDTH-1:0]    opCode,
    input  logic [REGISTER_WIDTH-1:0]  accumulator,
    input  logic [REGISTER_WIDTH-1:0]  register1,
    output logic                       ready,
    output logic                       done,
    output logic [REGISTER_WIDTH-1:0]  aluResult,
    output logic                       flagZero,
    output logic                       flagCarry,
    output logic                       flagNegative,
    output logic                       illegal
);

    localparam int W = REGISTER_WIDTH;

    // ------------------------------------------------------------------
    // Opcode decode. Bits above the encoded field must be zero, otherwise
    // the opcode is illegal regardless of its low bits.
    // ------------------------------------------------------------------
    logic    op_in_range;
    alu_op_e op_dec;
    logic    is_mul;

    assign op_in_range = ((opCode >> OPC_ENUM_WIDTH) == '0);
    assign op_dec      = alu_op_e'(opCode[OPC_ENUM_WIDTH-1:0]);

    // ------------------------------------------------------------------
    // Multiplier (optional)
    // ------------------------------------------------------------------
    logic [2*W-1:0] mul_product;
    logic           mul_last;

    alu_state_e state_reg;
    alu_state_e state_next;

`ifdef MULTICYCLE_ALU_MUL_EN
    logic mul_load;

    assign is_mul   = op_in_range && (op_dec == OP_MUL);
    assign mul_load = start && (state_reg == ST_IDLE) && is_mul;

    shift_add_multiplier #(
        .WIDTH (W)
    ) u_mul (
        .clock        (clock),
        .resetN       (resetN),
        .load         (mul_load),
        .multiplicand (accumulator),
        .multiplier   (register1),
        .product      (mul_product),
        .last_step    (mul_last)
    );
`else
    // Without the multiplier, opcode 10 drops through to the illegal path.
    assign is_mul      = 1'b0;
    assign mul_product = '0;
    assign mul_last    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic complete;   // a completion is retired on this edge
    logic use_mul;    // that completion comes from the multiplier

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        complete   = 1'b0;
        use_mul    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        state_next = ST_MUL_RUN;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            ST_MUL_RUN: begin
                // start is ignored here; the multiplier holds its own operands
                if (mul_last) begin
                    complete   = 1'b1;
                    use_mul    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ready = (state_reg == ST_IDLE);

    // ------------------------------------------------------------------
    // Single-cycle datapath. Arithmetic is one bit wider than the operands
    // so the top bit is the carry (ADD/INC) or the borrow (SUB).
    // ------------------------------------------------------------------
    logic [W:0]   wide_sum;
    logic [W:0]   wide_diff;
    logic [W:0]   wide_inc;
    logic [W-1:0] sc_result;
    logic         sc_carry;
    logic         sc_legal;

    assign wide_sum  = {1'b0, accumulator} + {1'b0, register1};
    assign wide_diff = {1'b0, accumulator} - {1'b0, register1};
    assign wide_inc  = {1'b0, accumulator} + (W+1)'(1);

    always_comb begin
        sc_result = accumulator;
        sc_carry  = 1'b0;
        sc_legal  = op_in_range;
        case (op_dec)
            OP_NOP: begin
                sc_result = accumulator;
            end
            OP_ADD: begin
                sc_result = wide_sum[W-1:0];
                sc_carry  = wide_sum[W];
            end
            OP_SUB: begin
                sc_result = wide_diff[W-1:0];
                sc_carry  = wide_diff[W];
            end
            OP_INC: begin
                sc_result = wide_inc[W-1:0];
                sc_carry  = wide_inc[W];
            end
            OP_AND: begin
                sc_result = accumulator & register1;
            end
            OP_OR: begin
                sc_result = accumulator | register1;
            end
            OP_XOR: begin
                sc_result = accumulator ^ register1;
            end
            OP_NOT: begin
                sc_result = ~accumulator;
            end
            OP_SHL: begin
                sc_result = {accumulator[W-2:0], 1'b0};
                sc_carry  = accumulator[W-1];
            end
            OP_SHR: begin
                sc_result = {1'b0, accumulator[W-1:1]};
                sc_carry  = accumulator[0];
            end
            default: begin
                // includes OP_MUL; when the multiplier is built, MUL never
                // retires through this path so the value here is unused
                sc_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Completion mux: multiplier result or single-cycle result
    // ------------------------------------------------------------------
    logic [W-1:0] fin_result;
    logic         fin_carry;
    logic         fin_legal;

    always_comb begin
        fin_result = sc_result;
        fin_carry  = sc_carry;
        fin_legal  = sc_legal;
        if (use_mul) begin
            fin_result = mul_product[W-1:0];
            fin_carry  = |mul_product[2*W-1:W];
            fin_legal  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result / flag registers. An illegal completion only raises `illegal`;
    // the result and the arithmetic flags keep the previous legal values.
    // ------------------------------------------------------------------
    logic         done_reg;
    logic [W-1:0] result_reg;
    alu_flags_t   flags_reg;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            done_reg   <= 1'b0;
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            done_reg <= complete;
            if (complete) begin
                if (fin_legal) begin
                    result_reg         <= fin_result;
                    flags_reg.zero     <= (fin_result == '0);
                    flags_reg.carry    <= fin_carry;
                    flags_reg.negative <= fin_result[W-1];
                    flags_reg.illegal  <= 1'b0;
                end else begin
                    flags_reg.illegal  <= 1'b1;
                end
            end
        end
    end

    assign done         = done_reg;
    assign aluResult    = result_reg;
    assign flagZero     = flags_reg.zero;
    assign flagCarry    = flags_reg.carry;
    assign flagNegative = flags_reg.negative;
    assign illegal      = flags_reg.illegal;

endmodule
